// File: rtl/mbist_controller.sv
// March-style memory BIST controller: for each of six background patterns,
// write the whole memory, read it back, and record the first miscompare.
module mbist_controller #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8  // must equal the decoder data_t width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [2:0]        q,
    input  logic [DATA_W-1:0] data_t,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_q
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]      LAST_Q    = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [2:0]          r_q;
    logic [2:0]          w_qNext;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addrNext;
    logic                w_clearFail;
    logic                r_cmpValid;
    logic [ADDR_W-1:0]   r_cmpAddr;
    logic                r_fail;
    logic [ADDR_W-1:0]   r_failAddr;
    logic [2:0]          r_failQ;
    logic                w_mismatch;

    // Sequencer registers: state, pattern index and address; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= 3'd0;
            r_addr  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_q     <= w_qNext;
            r_addr  <= w_addrNext;
        end
    end

    // Next-state and strobe decode; addr wraps naturally so CHECK always sees addr=0.
    always_comb begin
        w_stateNext = r_state;
        w_qNext     = r_q;
        w_addrNext  = r_addr;
        w_clearFail = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_stateNext = WRITE;
                    w_qNext     = 3'd0;
                    w_addrNext  = '0;
                    w_clearFail = 1'b1;
                end
            end
            WRITE: begin
                wr_en      = 1'b1;
                busy       = 1'b1;
                w_addrNext = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_stateNext = READ;
                end
            end
            READ: begin
                rd_en      = 1'b1;
                busy       = 1'b1;
                w_addrNext = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_stateNext = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (r_q == LAST_Q) begin
                    w_stateNext = DONE;
                end else begin
                    w_stateNext = WRITE;
                    w_qNext     = r_q + 3'd1;
                    w_addrNext  = '0;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Read data lags rd_en by one cycle, so the compare uses a delayed valid/address;
    // q has not yet moved on, even when the last read lands in CHECK.
    assign w_mismatch = r_cmpValid && (rdata != data_t);

    // Compare pipeline and sticky first-failure capture; a new run clears the record.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmpValid <= 1'b0;
            r_cmpAddr  <= '0;
            r_fail     <= 1'b0;
            r_failAddr <= '0;
            r_failQ    <= 3'd0;
        end else begin
            r_cmpValid <= rd_en;
            r_cmpAddr  <= r_addr;
            if (w_clearFail) begin
                r_fail     <= 1'b0;
                r_failAddr <= '0;
                r_failQ    <= 3'd0;
            end else if (w_mismatch && !r_fail) begin
                r_fail     <= 1'b1;
                r_failAddr <= r_cmpAddr;
                r_failQ    <= r_q;
            end
        end
    end

    assign q         = r_q;
    assign addr      = r_addr;
    assign wdata     = data_t;
    assign fail      = r_fail;
    assign fail_addr = r_failAddr;
    assign fail_q    = r_failQ;

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller: a 16x8 memory model with selectable faults,
// a pattern decoder, and a run-level scoreboard of expected outcomes.
module tb_mbist_controller;

    localparam int ADDR_W     = 4;
    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int RUN_CYCLES = 6 * (2 * DEPTH + 1);
    localparam int NO_FAULT   = 0;
    localparam int STUCK_A5B0 = 1;
    localparam int A15_ONES   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        q;
    logic [7:0]        data_t;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_q;

    logic [7:0] mem [DEPTH];
    int         faultSel = NO_FAULT;
    int         assertCount = 0;
    int         failCount = 0;

    typedef struct {
        int         doneCycle;
        logic       expFail;
        logic [2:0] expFailQ;
        logic [3:0] expFailAddr;
        int         failCycle;
    } runExp_t;

    runExp_t    sbQueue [$];
    logic [2:0] qSeq [$];

    mbist_controller #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .q         (q),
        .data_t    (data_t),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_q    (fail_q)
    );

    always #5 clk = ~clk;

    // Background-pattern decoder
    function automatic logic [7:0] patternOf(input logic [2:0] qv);
        case (qv)
            3'd0:    return 8'h00;
            3'd1:    return 8'hFF;
            3'd2:    return 8'h55;
            3'd3:    return 8'hAA;
            3'd4:    return 8'h33;
            3'd5:    return 8'hCC;
            default: return 8'h00;
        endcase
    endfunction

    assign data_t = patternOf(q);

    // Memory model with fault injection on the read path; read data lands one cycle later
    always @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) begin
            if (faultSel == STUCK_A5B0 && addr == 4'd5)
                rdata <= mem[addr] & 8'hFE;
            else if (faultSel == A15_ONES && addr == 4'd15)
                rdata <= 8'hFF;
            else
                rdata <= mem[addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_q"},         32'(q),         32'd0);
        checkOutput({tag, "_addr"},      32'(addr),      32'd0);
        checkOutput({tag, "_wr_en"},     32'(wr_en),     32'd0);
        checkOutput({tag, "_rd_en"},     32'(rd_en),     32'd0);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_fail"},      32'(fail),      32'd0);
        checkOutput({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
        checkOutput({tag, "_fail_q"},    32'(fail_q),    32'd0);
    endtask

    // One run: pulse start, optionally re-pulse start or assert rst mid-run, then score the outcome
    task automatic applyStimulus(input string tag, input int fault, input int repulseAt,
                                 input int resetAt, input runExp_t exp);
        int     overlap   = 0;
        int     failCycle = -1;
        int     doneCycle = -1;
        bit     aborted   = 1'b0;
        runExp_t got;

        @(negedge clk);
        faultSel = fault;
        start    = 1'b1;
        if (resetAt == 0) sbQueue.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, "_start_fail"}, 32'(fail), 32'd0);
        checkOutput({tag, "_start_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_start_q"},    32'(q),    32'd0);
        checkOutput({tag, "_start_addr"}, 32'(addr), 32'd0);

        qSeq.delete();
        qSeq.push_back(q);
        for (int n = 2; n <= RUN_CYCLES + 20 && doneCycle < 0 && !aborted; n++) begin
            start = (n == repulseAt + 1);
            rst   = (n == resetAt + 1);
            @(posedge clk);
            #1;
            if (rst) begin
                rst     = 1'b0;
                start   = 1'b0;
                aborted = 1'b1;
                checkResetValues({tag, "_midrun_rst"});
            end else begin
                if (wr_en && rd_en) overlap++;
                if (busy && q != qSeq[$]) qSeq.push_back(q);
                if (fail && failCycle < 0) failCycle = n;
                if (done) doneCycle = n;
            end
        end
        start = 1'b0;

        if (aborted) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, "_aborted_done"}, 32'(done), 32'd0);
                checkOutput({tag, "_aborted_fail"}, 32'(fail), 32'd0);
            end
        end else begin
            checkOutput({tag, "_sb_nonempty"}, 32'(sbQueue.size() > 0), 32'd1);
            if (sbQueue.size() > 0) begin
                got = sbQueue.pop_front();
                checkOutput({tag, "_done_cycle"}, 32'(doneCycle), 32'(got.doneCycle));
                checkOutput({tag, "_fail"},       32'(fail),      32'(got.expFail));
                checkOutput({tag, "_fail_q"},     32'(fail_q),    32'(got.expFailQ));
                checkOutput({tag, "_fail_addr"},  32'(fail_addr), 32'(got.expFailAddr));
                checkOutput({tag, "_fail_cycle"}, 32'(failCycle), 32'(got.failCycle));
            end
            checkOutput({tag, "_wr_rd_overlap"}, 32'(overlap), 32'd0);
            checkOutput({tag, "_q_seq_len"}, 32'(qSeq.size()), 32'd6);
            for (int i = 0; i < qSeq.size() && i < 6; i++)
                checkOutput({tag, "_q_seq"}, 32'(qSeq[i]), 32'(i));
        end
    endtask

    // Test sequence
    initial begin
        runExp_t e;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        // Fault-free run: done at cycle 199, no failure
        e = '{doneCycle: RUN_CYCLES + 1, expFail: 1'b0, expFailQ: 3'd0, expFailAddr: 4'd0, failCycle: -1};
        applyStimulus("clean", NO_FAULT, 0, 0, e);

        // Bit 0 of address 5 stuck at 0: first caught on pattern 1 (0xFF), read at cycle 55
        e = '{doneCycle: RUN_CYCLES + 1, expFail: 1'b1, expFailQ: 3'd1, expFailAddr: 4'd5, failCycle: 57};
        applyStimulus("stuck", STUCK_A5B0, 0, 0, e);

        // Restart from DONE with the fault removed: fail clears on the start edge
        e = '{doneCycle: RUN_CYCLES + 1, expFail: 1'b0, expFailQ: 3'd0, expFailAddr: 4'd0, failCycle: -1};
        applyStimulus("rerun", NO_FAULT, 0, 0, e);

        // Address 15 always 0xFF: mismatch on pattern 0, compared in the CHECK cycle (33)
        e = '{doneCycle: RUN_CYCLES + 1, expFail: 1'b1, expFailQ: 3'd0, expFailAddr: 4'd15, failCycle: 34};
        applyStimulus("a15", A15_ONES, 0, 0, e);

        // start re-pulsed while busy is ignored
        e = '{doneCycle: RUN_CYCLES + 1, expFail: 1'b0, expFailQ: 3'd0, expFailAddr: 4'd0, failCycle: -1};
        applyStimulus("repulse", NO_FAULT, 50, 0, e);

        // rst at cycle 100 aborts the run, then a fresh full run
        applyStimulus("abort", STUCK_A5B0, 0, 100, e);
        applyStimulus("after_abort", NO_FAULT, 0, 0, e);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
